// File: rtl/seven_segment_pkg.sv
// ---------------------------------------------------------------------------
// seven_segment_pkg
// Shared definitions for the seven-segment scan driver and scan decoder:
//   - scan_state_t  : decoder FSM state encoding
//   - SEG_TABLE     : active-low segment patterns for hex digits 0..F
//                     (bit0 = a .. bit6 = g, a 0 lights the segment)
//   - polarity constants for segment and digit-enable lines
//   - helpers for the active-low one-cold digit enable vector
// ---------------------------------------------------------------------------
package seven_segment_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_LOCKED = 2'd2
   } scan_state_t;

   // Both segment lines and digit enables are active-low.
   localparam logic       SEG_ON    = 1'b0;
   localparam logic       EN_ON     = 1'b0;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [7:0] EN_NONE   = 8'hFF;

   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   // Legal enable vector: exactly one digit driven active.
   function automatic logic en_is_legal(input logic [7:0] en);
      int unsigned active;
      active = 0;
      for (int i = 0; i < 8; i++) begin
         if (en[i] == EN_ON) active++;
      end
      return (active == 1);
   endfunction

   // Index of the active (low) enable bit; only meaningful when legal.
   function automatic logic [2:0] en_index(input logic [7:0] en);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (en[i] == EN_ON) idx = 3'(i);
      end
      return idx;
   endfunction

   function automatic logic [7:0] index_onehot(input logic [2:0] idx);
      return 8'b1 << idx;
   endfunction

endpackage

// File: rtl/seven_segment_pattern_decode.sv
// ---------------------------------------------------------------------------
// seven_segment_pattern_decode
// Combinational lookup of an active-low 7-segment pattern in SEG_TABLE.
//   pattern : 7-bit active-low segment pattern (bit0 = a .. bit6 = g)
//   value   : hex value 0..F of the matching entry (0 when no match)
//   hit     : 1 when the pattern is one of the 16 table entries
// ---------------------------------------------------------------------------
module seven_segment_pattern_decode
   import seven_segment_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] value,
   output logic       hit
);

   logic [15:0] match;

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_match
         assign match[gi] = (pattern == SEG_TABLE[gi]);
      end
   endgenerate

   // Table entries are distinct, so at most one match bit is set.
   always_comb begin
      value = 4'd0;
      hit   = |match;
      for (int i = 0; i < 16; i++) begin
         if (match[i]) value = 4'(i);
      end
   end

endmodule

// File: rtl/seven_segment_scan_decoder.sv
// ---------------------------------------------------------------------------
// seven_segment_scan_decoder
// Recovers per-digit hex values from a multiplexed (scanned) seven-segment
// display bus. A scan slot is accepted once {enable, segments} has been
// stable for STABLE_CYCLES synchronized samples with exactly one digit
// enabled; each stable interval is accepted once.
//
// Parameters
//   STABLE_CYCLES  : identical samples needed to accept a slot (2..255)
//   TIMEOUT_CYCLES : length of the digit-activity window (16..2^24-1)
// Ports
//   i_Clk             : clock, rising edge
//   i_Rst             : asynchronous active-high reset
//   i_Segment_Display : active-low segments, bit0 = a .. bit6 = g
//   i_Segment_En      : active-low digit enables, bit n = digit n
//   o_Digit_Value     : nibble n = last decoded hex value of digit n
//   o_Digit_Valid     : bit n = last accepted pattern of digit n was 0..F
//   o_Active_Mask     : digits accepted during the previous window
//   o_Update          : one-cycle pulse per accepted slot
//   o_Update_Index    : digit index of the latest accepted slot
// ---------------------------------------------------------------------------
module seven_segment_scan_decoder
   import seven_segment_pkg::*;
#(
   parameter int STABLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic        i_Clk,
   input  logic        i_Rst,
   input  logic [6:0]  i_Segment_Display,
   input  logic [7:0]  i_Segment_En,
   output logic [31:0] o_Digit_Value,
   output logic [7:0]  o_Digit_Valid,
   output logic [7:0]  o_Active_Mask,
   output logic        o_Update,
   output logic [2:0]  o_Update_Index
);

   localparam logic [7:0]  STABLE_TARGET = 8'(STABLE_CYCLES);
   localparam logic [23:0] WIN_LAST      = 24'(TIMEOUT_CYCLES - 1);

   // ---------------- input synchronizer (idle value = all ones) ----------
   logic [7:0] en_s1_reg,  en_s2_reg;
   logic [6:0] seg_s1_reg, seg_s2_reg;

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         en_s1_reg  <= EN_NONE;
         en_s2_reg  <= EN_NONE;
         seg_s1_reg <= SEG_BLANK;
         seg_s2_reg <= SEG_BLANK;
      end else begin
         en_s1_reg  <= i_Segment_En;
         en_s2_reg  <= en_s1_reg;
         seg_s1_reg <= i_Segment_Display;
         seg_s2_reg <= seg_s1_reg;
      end
   end

   // ---------------- scan slot FSM ---------------------------------------
   scan_state_t state_reg, state_next;
   logic [7:0]  cnt_reg, cnt_next;
   logic [14:0] last_reg;          // previous {enable, segments} sample
   logic        sample_changed;
   logic        en_legal;
   logic        accept;
   logic [2:0]  acc_idx;
   logic [7:0]  accept_onehot;

   assign sample_changed = ({en_s2_reg, seg_s2_reg} != last_reg);
   assign en_legal       = en_is_legal(en_s2_reg);
   assign acc_idx        = en_index(en_s2_reg);
   assign accept_onehot  = accept ? index_onehot(acc_idx) : 8'h00;

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= 8'd0;
         last_reg  <= {EN_NONE, SEG_BLANK};
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         last_reg  <= {en_s2_reg, seg_s2_reg};
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      accept     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (en_legal) begin
               state_next = ST_SETTLE;
               cnt_next   = 8'd1;
            end
         end
         ST_SETTLE: begin
            if (!en_legal) begin
               state_next = ST_IDLE;
               cnt_next   = 8'd0;
            end else if (sample_changed) begin
               cnt_next = 8'd1;
            end else if (cnt_reg == STABLE_TARGET - 8'd1) begin
               // This sample completes the stable run.
               accept     = 1'b1;
               state_next = ST_LOCKED;
               cnt_next   = STABLE_TARGET;
            end else begin
               cnt_next = cnt_reg + 8'd1;
            end
         end
         ST_LOCKED: begin
            // Stay until the sample changes so one interval yields one update.
            if (sample_changed) begin
               if (en_legal) begin
                  state_next = ST_SETTLE;
                  cnt_next   = 8'd1;
               end else begin
                  state_next = ST_IDLE;
                  cnt_next   = 8'd0;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
            cnt_next   = 8'd0;
         end
      endcase
   end

   // ---------------- pattern decode --------------------------------------
   logic [3:0] dec_value;
   logic       dec_hit;

   seven_segment_pattern_decode u_decode (
      .pattern (seg_s2_reg),
      .value   (dec_value),
      .hit     (dec_hit)
   );

   // ---------------- update pulse and index ------------------------------
   logic       update_reg;
   logic [2:0] update_idx_reg;

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         update_reg     <= 1'b0;
         update_idx_reg <= 3'd0;
      end else begin
         update_reg <= accept;
         if (accept) update_idx_reg <= acc_idx;
      end
   end

   assign o_Update       = update_reg;
   assign o_Update_Index = update_idx_reg;

   // ---------------- per-digit value / valid storage ---------------------
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_digit
         logic [3:0] nib_reg;
         logic       vld_reg;

         always_ff @(posedge i_Clk or posedge i_Rst) begin
            if (i_Rst) begin
               nib_reg <= 4'd0;
               vld_reg <= 1'b0;
            end else if (accept_onehot[gi]) begin
               // Unknown patterns (incl. blank) drop valid but keep the value.
               if (dec_hit) begin
                  nib_reg <= dec_value;
                  vld_reg <= 1'b1;
               end else begin
                  vld_reg <= 1'b0;
               end
            end
         end

         assign o_Digit_Value[4*gi +: 4] = nib_reg;
         assign o_Digit_Valid[gi]        = vld_reg;
      end
   endgenerate

   // ---------------- activity window -------------------------------------
   logic [23:0] win_cnt_reg;
   logic [7:0]  seen_reg;
   logic [7:0]  mask_reg;
   logic        win_wrap;

   assign win_wrap = (win_cnt_reg == WIN_LAST);

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         win_cnt_reg <= 24'd0;
         seen_reg    <= 8'h00;
         mask_reg    <= 8'h00;
      end else if (win_wrap) begin
         // An acceptance on the wrap cycle belongs to the closing window.
         win_cnt_reg <= 24'd0;
         mask_reg    <= seen_reg | accept_onehot;
         seen_reg    <= 8'h00;
      end else begin
         win_cnt_reg <= win_cnt_reg + 24'd1;
         seen_reg    <= seen_reg | accept_onehot;
      end
   end

   assign o_Active_Mask = mask_reg;

endmodule

// File: doc/seven_segment_scan_decoder.md
SEVEN_SEGMENT_SCAN_DECODER -- requirements
Module: seven_segment_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 16: consecutive identical samples required before a scan slot is accepted (legal range 2..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000: length of the digit-activity window (legal range 16..2^24-1).
REQ-003 SHALL have port i_Clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port i_Rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port i_Segment_Display, input, 7: active-low segment lines, bit0=a .. bit6=g.
REQ-006 SHALL have port i_Segment_En, input, 8: active-low digit enables, bit n = digit n.
REQ-007 SHALL have port o_Digit_Value, output, 32: nibble n (bits 4n+3:4n) is the last decoded hex value of digit n.
REQ-008 SHALL have port o_Digit_Valid, output, 8: bit n set when the last accepted pattern for digit n decoded to 0-F.
REQ-009 SHALL have port o_Active_Mask, output, 8: digits accepted at least once during the previous timeout window.
REQ-010 SHALL have port o_Update, output, 1: one-cycle pulse on each accepted slot.
REQ-011 SHALL have port o_Update_Index, output, 3: digit index of the current o_Update; held between pulses.

Function
REQ-012 SHALL register both inputs through a two-flop synchronizer; all decisions use the second stage (2-cycle input latency).
REQ-013 SHALL treat the enable vector as legal only when exactly one bit is 0.
REQ-014 SHALL implement the FSM IDLE, SETTLE, LOCKED.
REQ-015 SHALL use IDLE when the enable vector is illegal, and SHALL move to SETTLE with the stability counter at 1 on a legal enable.
REQ-016 SHALL, in SETTLE, increment the counter while {enable, segments} is unchanged and restart at 1 on any change; an illegal enable SHALL move the FSM to IDLE.
REQ-017 SHALL, when the counter reaches STABLE_CYCLES, accept the slot, enter LOCKED and pulse o_Update in the same cycle.
REQ-018 SHALL, on acceptance, set o_Update_Index to the index of the low enable bit.
REQ-019 SHALL accept each stable interval exactly once: LOCKED SHALL hold until the sample changes.
REQ-020 SHALL, on a change while LOCKED, go to SETTLE for a legal enable or to IDLE for an illegal one.
REQ-021 SHALL decode with this active-low table: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
REQ-022 SHALL, when an accepted pattern is in the table, write the nibble and set o_Digit_Valid[n].
REQ-023 SHALL, when an accepted pattern is not in the table (including blank 7F), clear o_Digit_Valid[n] and leave the nibble unchanged.
REQ-024 SHALL set a seen bit for the digit on each accepted slot.
REQ-025 SHALL run a free window counter from 0 to TIMEOUT_CYCLES-1; on wrap it SHALL copy the seen bits to o_Active_Mask and clear them.
REQ-026 SHALL, when an acceptance and a window wrap coincide, include the accepting digit in the copied mask and leave its seen bit cleared.
REQ-027 SHALL not let scan rate affect outputs beyond these rules; it SHALL impose no ordering constraint on digit indices.

Reset
REQ-028 SHALL, on i_Rst high, immediately clear the FSM (to IDLE), both synchronizer stages (to all-ones, i.e. inactive), all counters, seen bits, o_Digit_Value, o_Digit_Valid, o_Active_Mask, o_Update and o_Update_Index.
REQ-029 SHALL abandon a slot in SETTLE when reset asserts mid-settle; after release that slot SHALL need a full STABLE_CYCLES again.

Structure
REQ-030 SHALL keep the FSM state encoding, the 16-entry segment table and the active-low polarity constants in the shared package seven_segment_pkg, where the scanning driver also uses them.
REQ-031 SHALL place the table lookup in a combinational sub-module, seven_segment_pattern_decode (7-bit pattern in; 4-bit value and hit flag out).

Verification
REQ-032 SHALL check: enable FE with segments 30 held 20 cycles (STABLE_CYCLES=16) -> exactly one o_Update, index 0, o_Digit_Value[3:0]=3, o_Digit_Valid[0]=1.
REQ-033 SHALL check: segments toggle 30/24 every 8 cycles with enable FD -> no o_Update; then 24 held 16 cycles -> one o_Update, index 1, nibble 2.
REQ-034 SHALL check: enable F3 (two active) or FF held 100 cycles -> no o_Update and FSM stays IDLE.
REQ-035 SHALL check: enable 7F with segments 7F accepted -> o_Digit_Valid[7]=0 and the prior nibble 7 retained.
REQ-036 SHALL check: TIMEOUT_CYCLES=64 with digits 0 and 2 scanned -> o_Active_Mask=05 after the window; the next window with no input -> 00.
REQ-037 SHALL check: i_Rst asserted at settle count 10 -> outputs clear immediately; after release, o_Update occurs only after 16 further stable cycles.
